tcb_lib_arbiter: RTL

//  SPN-to-1 TCB arbiter that shares one memory manager port between several subordinate requesters.

---
 rtl/tcb_lib_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tcb_lib_arbiter.sv
// SPN-to-1 TCB arbiter: round-robin or fixed-priority grant, locked across a stalled request.
// Responses are routed back to the issuing port DLY cycles after each manager transfer.
module tcb_lib_arbiter #(
  parameter int SPN = 2,
  parameter int ABW = 32,
  parameter int DBW = 32,
  parameter int DLY = 1,
  parameter int PRI = 0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [SPN-1:0]     sub_vld,
  input  logic [SPN-1:0]     sub_wen,
  input  logic [SPN*ABW-1:0] sub_adr,
  input  logic [SPN*DBW/8-1:0] sub_ben,
  input  logic [SPN*DBW-1:0] sub_wdt,
  output logic [SPN-1:0]     sub_rdy,
  output logic [SPN-1:0]     sub_rsp,
  output logic [DBW-1:0]     sub_rdt,
  output logic               sub_err,
  output logic               man_vld,
  output logic               man_wen,
  output logic [ABW-1:0]     man_adr,
  output logic [DBW/8-1:0]   man_ben,
  output logic [DBW-1:0]     man_wdt,
  input  logic               man_rdy,
  input  logic [DBW-1:0]     man_rdt,
  input  logic               man_err
);

  localparam int IW  = (SPN > 1) ? $clog2(SPN) : 1;
  localparam int CW  = IW + 1;
  localparam int BEW = DBW / 8;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t        r_state;
  logic [IW-1:0] r_lock_idx;
  logic [IW-1:0] r_ptr;

  logic [IW-1:0] w_gnt;
  logic          w_gnt_vld;
  logic [CW-1:0] w_cand;
  logic          w_trn;

  // A stalled request keeps its grant so a later, higher-priority request cannot preempt it.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    w_cand    = '0;
    if (r_state == LOCK) begin
      w_gnt     = r_lock_idx;
      w_gnt_vld = 1'b1;
    end else if (PRI == 0) begin
      for (int k = 0; k < SPN; k++) begin
        w_cand = {1'b0, r_ptr} + CW'(k);
        if (w_cand >= CW'(SPN)) w_cand = w_cand - CW'(SPN);
        if (!w_gnt_vld && sub_vld[w_cand[IW-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = w_cand[IW-1:0];
        end
      end
    end else begin
      for (int k = SPN-1; k >= 0; k--) begin
        if (sub_vld[k]) begin
          w_gnt_vld = 1'b1;
          w_gnt     = IW'(k);
        end
      end
    end
    if (rst) w_gnt_vld = 1'b0;
  end

  assign man_vld = w_gnt_vld & sub_vld[w_gnt];
  assign man_wen = sub_wen[w_gnt];
  assign man_adr = sub_adr[w_gnt*ABW +: ABW];
  assign man_ben = sub_ben[w_gnt*BEW +: BEW];
  assign man_wdt = sub_wdt[w_gnt*DBW +: DBW];
  assign w_trn   = man_vld & man_rdy;

  always_comb begin
    sub_rdy = '0;
    if (w_gnt_vld) sub_rdy[w_gnt] = man_rdy;
  end

  assign sub_rdt = man_rdt;
  assign sub_err = man_err;

  // The lock is released on any cycle the manager is ready, even if the locked port dropped vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_lock_idx <= '0;
      r_ptr      <= '0;
    end else begin
      case (r_state)
        IDLE: if (man_vld && !man_rdy) begin
          r_state    <= LOCK;
          r_lock_idx <= w_gnt;
        end
        LOCK: if (man_rdy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (PRI == 0 && w_trn)
        r_ptr <= (w_gnt == IW'(SPN-1)) ? '0 : w_gnt + 1'b1;
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      always_comb begin
        sub_rsp = '0;
        if (w_trn) sub_rsp[w_gnt] = 1'b1;
      end
    end else begin : g_dly
      logic [DLY-1:0] r_pipe_vld;
      logic [IW-1:0]  r_pipe_idx [DLY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_pipe_vld <= '0;
          for (int i = 0; i < DLY; i++) r_pipe_idx[i] <= '0;
        end else begin
          r_pipe_vld[0] <= w_trn;
          r_pipe_idx[0] <= w_gnt;
          for (int i = 1; i < DLY; i++) begin
            r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_pipe_idx[i] <= r_pipe_idx[i-1];
          end
        end
      end

      always_comb begin
        sub_rsp = '0;
        if (r_pipe_vld[DLY-1]) sub_rsp[r_pipe_idx[DLY-1]] = 1'b1;
      end
    end
  endgenerate

endmodule
